// File: rtl/contador_ad_param.sv
// Up/down BCD-displayable counter stepped by key-scan codes, with a dynamic upper
// bound, load, wrap/saturate limit handling and overflow/underflow pulses.
module contador_ad_param #(
  parameter int          N          = 7,
  parameter int          MIN        = 1,
  parameter int          MAX        = 99,
  parameter int          PASO       = 1,
  parameter int          WRAP       = 1,
  parameter logic [1:0]  EN_VAL     = 2'd2,
  parameter logic [7:0]  ESTADO_VAL = 8'h7D,
  parameter logic [7:0]  COD_UP     = 8'h73,
  parameter logic [7:0]  COD_DN     = 8'h72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   estado,
  input  logic [1:0]   en,
  input  logic [7:0]   Cambio,
  input  logic         got_data,
  input  logic [N-1:0] limite_max,
  input  logic         carga,
  input  logic [N-1:0] valor_carga,
  output logic [N-1:0] Cuenta,
  output logic         desborde,
  output logic         subdesborde,
  output logic [3:0]   decenas,
  output logic [3:0]   unidades
);

  localparam int         W       = N + 1;
  localparam logic [W-1:0] MIN_W  = W'(MIN);
  localparam logic [W-1:0] MAX_W  = W'(MAX);
  localparam logic [W-1:0] PASO_W = W'(PASO);
  localparam logic [3:0] MIN_DEC = 4'(MIN / 10);
  localparam logic [3:0] MIN_UNI = 4'(MIN % 10);

  logic [N-1:0] cuenta_q;
  logic [W-1:0] cuenta_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         gd_q, arm_q;
  logic [3:0]   dec_q, uni_q, dec_d, uni_d;

  logic [W-1:0] lim, lm_w, cur, base, ld, up_sum;
  logic [7:0]   c8;
  logic         pulso, step;

  // arm_q blocks a step until got_data has been seen low after reset, so a
  // level already high at reset release never counts as a rising edge.
  assign pulso = got_data & ~gd_q & arm_q;
  assign step  = (en == EN_VAL) && (estado == ESTADO_VAL) && pulso &&
                 ((Cambio == COD_UP) || (Cambio == COD_DN));

  always_comb begin
    lm_w = {1'b0, limite_max};
    if (lm_w == '0 || lm_w > MAX_W) lim = MAX_W;
    else                            lim = lm_w;
    if (lim < MIN_W) lim = MIN_W;

    cur  = {1'b0, cuenta_q};
    base = cur;
    if (base > lim)   base = lim;
    if (base < MIN_W) base = MIN_W;

    ld = {1'b0, valor_carga};
    if (ld > lim)   ld = lim;
    if (ld < MIN_W) ld = MIN_W;

    up_sum = base + PASO_W;

    cuenta_d = cur;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (carga) begin
      cuenta_d = ld;
    end else if (step) begin
      if (Cambio == COD_UP) begin
        if (up_sum <= lim) cuenta_d = up_sum;
        else begin
          cuenta_d = (WRAP != 0) ? MIN_W : lim;
          ovf_d    = 1'b1;
        end
      end else begin
        if (base >= MIN_W + PASO_W) cuenta_d = base - PASO_W;
        else begin
          cuenta_d = (WRAP != 0) ? lim : MIN_W;
          unf_d    = 1'b1;
        end
      end
    end else if (cur > lim) begin
      cuenta_d = lim;
    end
  end

  // Count never exceeds 99, so an 8-bit view is enough for the BCD split.
  assign c8    = 8'(cuenta_q);
  assign dec_d = 4'(c8 / 8'd10);
  assign uni_d = 4'(c8 % 8'd10);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cuenta_q <= N'(MIN);
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      gd_q     <= 1'b0;
      arm_q    <= 1'b0;
      dec_q    <= MIN_DEC;
      uni_q    <= MIN_UNI;
    end else begin
      cuenta_q <= cuenta_d[N-1:0];
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      gd_q     <= got_data;
      arm_q    <= arm_q | ~got_data;
      dec_q    <= dec_d;
      uni_q    <= uni_d;
    end
  end

  assign Cuenta      = cuenta_q;
  assign desborde    = ovf_q;
  assign subdesborde = unf_q;
  assign decenas     = dec_q;
  assign unidades    = uni_q;

endmodule

// File: tb/tb_contador_ad_param.sv
// Bench for contador_ad_param: three parameter sets driven in parallel, directed
// scenarios against fixed values plus a random run against a reference model.
module tb_contador_ad_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] estado, Cambio, valor8;
  logic [1:0] en;
  logic       got_data, carga;
  logic [6:0] limite_max, valor_carga;

  logic [6:0] cuenta_w [3];
  logic       ov_w [3];
  logic       un_w [3];
  logic [3:0] dec_w [3];
  logic [3:0] uni_w [3];

  int P_MIN [3]  = '{1, 1, 0};
  int P_MAX [3]  = '{99, 99, 59};
  int P_PASO [3] = '{1, 1, 5};
  int P_WRAP [3] = '{1, 0, 1};

  int m_cnt [3];
  bit m_ov [3];
  bit m_un [3];
  int m_dec [3];
  int m_uni [3];
  bit m_prev, m_arm;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  contador_ad_param u_def (
    .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(Cambio),
    .got_data(got_data), .limite_max(limite_max), .carga(carga),
    .valor_carga(valor_carga), .Cuenta(cuenta_w[0]), .desborde(ov_w[0]),
    .subdesborde(un_w[0]), .decenas(dec_w[0]), .unidades(uni_w[0]));

  contador_ad_param #(.WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(Cambio),
    .got_data(got_data), .limite_max(limite_max), .carga(carga),
    .valor_carga(valor_carga), .Cuenta(cuenta_w[1]), .desborde(ov_w[1]),
    .subdesborde(un_w[1]), .decenas(dec_w[1]), .unidades(uni_w[1]));

  contador_ad_param #(.MIN(0), .MAX(59), .PASO(5)) u_p5 (
    .clk(clk), .rst(rst), .estado(estado), .en(en), .Cambio(Cambio),
    .got_data(got_data), .limite_max(limite_max), .carga(carga),
    .valor_carga(valor_carga), .Cuenta(cuenta_w[2]), .desborde(ov_w[2]),
    .subdesborde(un_w[2]), .decenas(dec_w[2]), .unidades(uni_w[2]));

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = P_MIN[k];
      m_ov[k]  = 1'b0;
      m_un[k]  = 1'b0;
      m_dec[k] = P_MIN[k] / 10;
      m_uni[k] = P_MIN[k] % 10;
    end
    m_prev = 1'b0;
    m_arm  = 1'b0;
  endtask

  // Advance one clock: predict from the pre-edge inputs, then settle past the edge.
  task automatic tick();
    int nc [3];
    bit ov [3];
    bit un [3];
    bit pul, stp, up;
    int l, b, lm;
    pul = got_data && !m_prev && m_arm;
    stp = pul && en == 2'd2 && estado == 8'h7D && (Cambio == 8'h73 || Cambio == 8'h72);
    up  = (Cambio == 8'h73);
    lm  = int'(limite_max);
    for (int k = 0; k < 3; k++) begin
      l = (lm == 0) ? P_MAX[k] : ((lm < P_MAX[k]) ? lm : P_MAX[k]);
      if (l < P_MIN[k]) l = P_MIN[k];
      ov[k] = 1'b0;
      un[k] = 1'b0;
      if (carga) nc[k] = clampi(int'(valor_carga), P_MIN[k], l);
      else if (stp) begin
        b = clampi(m_cnt[k], P_MIN[k], l);
        if (up) begin
          if (b + P_PASO[k] <= l) nc[k] = b + P_PASO[k];
          else begin nc[k] = (P_WRAP[k] != 0) ? P_MIN[k] : l; ov[k] = 1'b1; end
        end else begin
          if (b - P_PASO[k] >= P_MIN[k]) nc[k] = b - P_PASO[k];
          else begin nc[k] = (P_WRAP[k] != 0) ? l : P_MIN[k]; un[k] = 1'b1; end
        end
      end
      else if (m_cnt[k] > l) nc[k] = l;
      else nc[k] = m_cnt[k];
    end
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 3; k++) begin
        m_dec[k] = m_cnt[k] / 10;
        m_uni[k] = m_cnt[k] % 10;
        m_cnt[k] = nc[k];
        m_ov[k]  = ov[k];
        m_un[k]  = un[k];
      end
      m_arm  = m_arm || !got_data;
      m_prev = got_data;
    end
  endtask

  task automatic load(input int v);
    carga       = 1'b1;
    valor_carga = 7'(v);
    tick();
    carga       = 1'b0;
  endtask

  task automatic key_step(input logic [7:0] code);
    estado   = 8'h7D;
    en       = 2'd2;
    Cambio   = code;
    got_data = 1'b1;
    tick();
  endtask

  task automatic key_rel();
    got_data = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; estado = 8'h00; en = 2'd0; Cambio = 8'h00; got_data = 1'b0;
    carga = 1'b0; valor_carga = '0; limite_max = '0;
    model_reset();
    tick(); tick();
    n_checks++; if (cuenta_w[0] !== 7'd1) begin n_fail++; $display("FAIL reset_cnt0 got=%0d exp=1", cuenta_w[0]); end
    n_checks++; if (cuenta_w[2] !== 7'd0) begin n_fail++; $display("FAIL reset_cnt2 got=%0d exp=0", cuenta_w[2]); end
    n_checks++; if ({ov_w[0], un_w[0]} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {ov_w[0], un_w[0]}); end
    n_checks++; if ({dec_w[0], uni_w[0]} !== 8'h01) begin n_fail++; $display("FAIL reset_bcd got=%h exp=01", {dec_w[0], uni_w[0]}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap_up();
    load(98);
    key_step(8'h73);
    n_checks++; if (cuenta_w[0] !== 7'd99 || ov_w[0] !== 1'b0) begin n_fail++; $display("FAIL up_to_99 got=%0d/%b exp=99/0", cuenta_w[0], ov_w[0]); end
    key_rel();
    n_checks++; if ({dec_w[0], uni_w[0]} !== 8'h99) begin n_fail++; $display("FAIL bcd_99 got=%h exp=99", {dec_w[0], uni_w[0]}); end
    key_step(8'h73);
    n_checks++; if (cuenta_w[0] !== 7'd1 || ov_w[0] !== 1'b1) begin n_fail++; $display("FAIL up_wrap got=%0d/%b exp=1/1", cuenta_w[0], ov_w[0]); end
    n_checks++; if (cuenta_w[1] !== 7'd99 || ov_w[1] !== 1'b1) begin n_fail++; $display("FAIL up_sat got=%0d/%b exp=99/1", cuenta_w[1], ov_w[1]); end
    key_rel();
    n_checks++; if (ov_w[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got=%b exp=0", ov_w[0]); end
    key_step(8'h73);
    n_checks++; if (cuenta_w[0] !== 7'd2 || ov_w[0] !== 1'b0) begin n_fail++; $display("FAIL up_to_2 got=%0d/%b exp=2/0", cuenta_w[0], ov_w[0]); end
    key_rel();
  endtask

  task automatic test_wrap_down();
    load(1);
    key_step(8'h72);
    n_checks++; if (cuenta_w[0] !== 7'd99 || un_w[0] !== 1'b1) begin n_fail++; $display("FAIL dn_wrap got=%0d/%b exp=99/1", cuenta_w[0], un_w[0]); end
    n_checks++; if (cuenta_w[1] !== 7'd1 || un_w[1] !== 1'b1) begin n_fail++; $display("FAIL dn_sat got=%0d/%b exp=1/1", cuenta_w[1], un_w[1]); end
    key_rel();
    n_checks++; if (un_w[0] !== 1'b0) begin n_fail++; $display("FAIL unf_one_cycle got=%b exp=0", un_w[0]); end
    limite_max = 7'd31;
    load(1);
    key_step(8'h72);
    n_checks++; if (cuenta_w[0] !== 7'd31) begin n_fail++; $display("FAIL dn_wrap_dyn got=%0d exp=31", cuenta_w[0]); end
    key_rel();
  endtask

  task automatic test_clamp();
    load(31);
    n_checks++; if (cuenta_w[0] !== 7'd31) begin n_fail++; $display("FAIL load_31 got=%0d exp=31", cuenta_w[0]); end
    limite_max = 7'd28;
    tick();
    n_checks++; if (cuenta_w[0] !== 7'd28 || {ov_w[0], un_w[0]} !== 2'b00) begin n_fail++; $display("FAIL clamp_28 got=%0d/%b%b exp=28/00", cuenta_w[0], ov_w[0], un_w[0]); end
    load(0);
    n_checks++; if (cuenta_w[0] !== 7'd1) begin n_fail++; $display("FAIL load_low got=%0d exp=1", cuenta_w[0]); end
    load(120);
    n_checks++; if (cuenta_w[0] !== 7'd28) begin n_fail++; $display("FAIL load_high got=%0d exp=28", cuenta_w[0]); end
    limite_max = 7'd0;
    tick();
  endtask

  task automatic test_gating();
    load(10);
    estado = 8'h7D; en = 2'd2; Cambio = 8'h73; got_data = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_checks++; if (cuenta_w[0] !== 7'd11) begin n_fail++; $display("FAIL held_high got=%0d exp=11", cuenta_w[0]); end
    key_rel();
    en = 2'd1; got_data = 1'b1; tick(); got_data = 1'b0; tick();
    n_checks++; if (cuenta_w[0] !== 7'd11) begin n_fail++; $display("FAIL en_gate got=%0d exp=11", cuenta_w[0]); end
    en = 2'd2; estado = 8'h00; got_data = 1'b1; tick(); got_data = 1'b0; tick();
    n_checks++; if (cuenta_w[0] !== 7'd11) begin n_fail++; $display("FAIL estado_gate got=%0d exp=11", cuenta_w[0]); end
    estado = 8'h7D; Cambio = 8'h41; got_data = 1'b1; tick(); got_data = 1'b0; tick();
    n_checks++; if (cuenta_w[0] !== 7'd11) begin n_fail++; $display("FAIL code_gate got=%0d exp=11", cuenta_w[0]); end
    carga = 1'b1; valor_carga = 7'd50;
    key_step(8'h73);
    carga = 1'b0;
    n_checks++; if (cuenta_w[0] !== 7'd50 || ov_w[0] !== 1'b0) begin n_fail++; $display("FAIL load_priority got=%0d/%b exp=50/0", cuenta_w[0], ov_w[0]); end
    key_rel();
  endtask

  task automatic test_reset_mid();
    load(57);
    key_step(8'h73);
    n_checks++; if (cuenta_w[2] !== 7'd0 || ov_w[2] !== 1'b1) begin n_fail++; $display("FAIL paso5_wrap got=%0d/%b exp=0/1", cuenta_w[2], ov_w[2]); end
    key_rel();
    load(57);
    tick();
    got_data = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (cuenta_w[2] !== 7'd0 || {dec_w[2], uni_w[2]} !== 8'h00) begin n_fail++; $display("FAIL async_rst_p5 got=%0d/%h exp=0/00", cuenta_w[2], {dec_w[2], uni_w[2]}); end
    n_checks++; if (cuenta_w[0] !== 7'd1 || ov_w[0] !== 1'b0) begin n_fail++; $display("FAIL async_rst_def got=%0d/%b exp=1/0", cuenta_w[0], ov_w[0]); end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (cuenta_w[0] !== 7'd1 || ov_w[0] !== 1'b0 || un_w[0] !== 1'b0) begin n_fail++; $display("FAIL high_at_release got=%0d/%b%b exp=1/00", cuenta_w[0], ov_w[0], un_w[0]); end
    key_rel();
    key_step(8'h73);
    n_checks++; if (cuenta_w[0] !== 7'd2) begin n_fail++; $display("FAIL step_after_rst got=%0d exp=2", cuenta_w[0]); end
    key_rel();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      valor8      = 8'($urandom_range(0, 255));
      estado      = ($urandom_range(0, 3) != 0) ? 8'h7D : valor8;
      en          = ($urandom_range(0, 3) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       Cambio = 8'($urandom_range(0, 255));
        1, 2, 3, 4: Cambio = 8'h72;
        default: Cambio = 8'h73;
      endcase
      got_data    = ($urandom_range(0, 1) != 0);
      carga       = ($urandom_range(0, 15) == 0);
      valor_carga = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 31) == 0)
        limite_max = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
      rst = ($urandom_range(0, 79) == 0);
      if (rst) begin
        #1;
        model_reset();
      end
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        n_checks++; if (cuenta_w[k] !== 7'(m_cnt[k])) begin n_fail++; $display("FAIL rnd_cnt inst=%0d cyc=%0d got=%0d exp=%0d", k, i, cuenta_w[k], m_cnt[k]); end
        n_checks++; if (ov_w[k] !== m_ov[k]) begin n_fail++; $display("FAIL rnd_ovf inst=%0d cyc=%0d got=%b exp=%b", k, i, ov_w[k], m_ov[k]); end
        n_checks++; if (un_w[k] !== m_un[k]) begin n_fail++; $display("FAIL rnd_unf inst=%0d cyc=%0d got=%b exp=%b", k, i, un_w[k], m_un[k]); end
        n_checks++; if (dec_w[k] !== 4'(m_dec[k]) || uni_w[k] !== 4'(m_uni[k])) begin n_fail++; $display("FAIL rnd_bcd inst=%0d cyc=%0d got=%0d%0d exp=%0d%0d", k, i, dec_w[k], uni_w[k], m_dec[k], m_uni[k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_clamp();
    test_gating();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
